shift_seq_ctrl: RTL and testbench

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

---
 rtl/shift_seq_pkg.sv | 25 ++
 rtl/shift_seq_if.sv | 28 ++
 rtl/shift_seq_step.sv | 45 ++++
 rtl/shift_seq_ctrl.sv | 108 ++++++++++
 tb/tb_shift_seq_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the sequential shifter controller.
// Build option: SHIFT_SEQ_ZERO_BYPASS_EN (see shift_seq_ctrl).
package shift_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COARSE = 2'd1,
        ST_FINE   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b11;

    localparam int COARSE_STEP = 8;
    localparam int ONEHOT_W    = 8;

    function automatic logic [ONEHOT_W-1:0] onehot8(
        input logic [2:0] amt
    );
        return ONEHOT_W'(1) << amt;
    endfunction

endpackage

// File: rtl/shift_seq_if.sv
// Request/response bundle between a shift client and shift_seq_ctrl.
interface shift_seq_if #(
    parameter int XLEN = 32
) ();

    localparam int SW = $clog2(XLEN);

    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic [XLEN-1:0] datain;
    logic [SW-1:0]   shamt;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] dataout;
    logic            busy;

    modport master (
        output in_valid, op, datain, shamt, out_ready,
        input  in_ready, out_valid, dataout, busy
    );

    modport slave (
        input  in_valid, op, datain, shamt, out_ready,
        output in_ready, out_valid, dataout, busy
    );

endinterface

// File: rtl/shift_seq_step.sv
// Single shift step: by 8 (coarse) or by a one-hot fine amount 0..7.
// Right shifts of SRA replicate the MSB, which the sequence never alters.
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]     din,
    input  logic [1:0]          op,
    input  logic                coarse,
    input  logic [ONEHOT_W-1:0] onehot,
    output logic [XLEN-1:0]     dout
);

    logic [3:0] amt;

    always_comb begin
        amt = '0;
        if (coarse) begin
            amt = 4'(COARSE_STEP);
        end else begin
            unique case (1'b1)
                onehot[0]: amt = 4'd0;
                onehot[1]: amt = 4'd1;
                onehot[2]: amt = 4'd2;
                onehot[3]: amt = 4'd3;
                onehot[4]: amt = 4'd4;
                onehot[5]: amt = 4'd5;
                onehot[6]: amt = 4'd6;
                onehot[7]: amt = 4'd7;
                default:   amt = 4'd0;
            endcase
        end
    end

    always_comb begin
        dout = din << amt;
        unique case (op)
            OP_SRL:  dout = din >> amt;
            OP_SRA:  dout = XLEN'($signed(din) >>> amt);
            default: dout = din << amt;
        endcase
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shifter: byte-wide coarse steps, then one fine step.
// Define SHIFT_SEQ_ZERO_BYPASS_EN to send shamt=0 straight to DONE.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    shift_seq_if.slave bus
);

    localparam int SW = $clog2(XLEN);
    localparam int CW = SW - 3;

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] COARSE = ST_COARSE;
    localparam logic [1:0] FINE   = ST_FINE;
    localparam logic [1:0] DONE   = ST_DONE;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] work_q, work_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      fine_q, fine_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] step_out;
    logic            zero_go;

`ifdef SHIFT_SEQ_ZERO_BYPASS_EN
    assign zero_go = (bus.shamt[2:0] == 3'd0);
`else
    assign zero_go = 1'b0;
`endif

    shift_step #(
        .XLEN (XLEN)
    ) u_step (
        .din    (work_q),
        .op     (op_q),
        .coarse (state_q == COARSE),
        .onehot (onehot8(fine_q)),
        .dout   (step_out)
    );

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        fine_d  = fine_q;
        op_d    = op_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d   = bus.op;
                    work_d = bus.datain;
                    cnt_d  = bus.shamt[SW-1:3];
                    fine_d = bus.shamt[2:0];
                    if (bus.shamt[SW-1:3] != '0) begin
                        state_d = COARSE;
                    end else if (zero_go) begin
                        state_d = DONE;
                    end else begin
                        state_d = FINE;
                    end
                end
            end
            COARSE: begin
                work_d = step_out;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FINE;
                end
            end
            FINE: begin
                work_d  = step_out;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            fine_q  <= '0;
            op_q    <= OP_SLL;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            fine_q  <= fine_d;
            op_q    <= op_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.dataout   = work_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed cases plus random
// traffic against a countdown/arithmetic reference model.
module tb_shift_seq_ctrl;

    logic clk;
    logic rst_n;

    shift_seq_if #(.XLEN(32)) bus ();

    shift_seq_ctrl #(
        .XLEN (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SHIFT_SEQ_ZERO_BYPASS_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 2;
`endif

    int vectors = 0;
    int miscompares = 0;

    // reference model: 0 idle, 1 working, 2 result pending
    int          m_st;
    int          m_left;
    logic [31:0] m_res;
    bit          m_zero;

    function automatic logic [31:0] ref_shift(
        input logic [1:0] o, input logic [31:0] d, input logic [4:0] s
    );
        case (o)
            2'b01:   return d >> s;
            2'b11:   return 32'($signed(d) >>> s);
            default: return d << s;
        endcase
    endfunction

    function automatic int ref_lat(input logic [4:0] s);
        if (s == 5'd0) return ZLAT;
        return int'(s >> 3) + 2;
    endfunction

    task automatic chk(
        input string nm, input logic [31:0] act, input logic [31:0] exp
    );
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st   = 0;
        m_left = 0;
        m_res  = '0;
        m_zero = 1'b1;
    endtask

    task automatic model_step();
        if (!rst_n) begin
            model_reset();
        end else begin
            case (m_st)
                0: if (bus.in_valid) begin
                    m_res  = ref_shift(bus.op, bus.datain, bus.shamt);
                    m_left = ref_lat(bus.shamt) - 1;
                    m_zero = 1'b0;
                    m_st   = (m_left == 0) ? 2 : 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_st = 2;
                end
                default: if (bus.out_ready) m_st = 0;
            endcase
        end
    endtask

    task automatic compare();
        chk("in_ready", 32'(bus.in_ready), 32'(m_st == 0));
        chk("busy", 32'(bus.busy), 32'(m_st != 0));
        chk("out_valid", 32'(bus.out_valid), 32'(m_st == 2));
        if (m_st == 2) chk("dataout", bus.dataout, m_res);
        if (m_zero) chk("dataout_reset", bus.dataout, 32'h0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic run(
        input logic [1:0] o, input logic [31:0] d, input logic [4:0] s,
        input logic [31:0] exp, input int exp_lat, input string nm
    );
        int lat;
        bus.op        = o;
        bus.datain    = d;
        bus.shamt     = s;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        lat = 0;
        do begin
            cycle();
            lat++;
            bus.in_valid = 1'b0;
            bus.op       = 2'($urandom);
            bus.datain   = $urandom;
            bus.shamt    = 5'($urandom);
        end while (!bus.out_valid && lat < 40);
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, " data"}, bus.dataout, exp);
        cycle();
    endtask

    task automatic hold_test();
        logic [31:0] hold;
        int n;
        bus.op        = 2'b01;
        bus.datain    = 32'h1234_5678;
        bus.shamt     = 5'd12;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        cycle();
        bus.op     = 2'b00;
        bus.datain = 32'h0000_00F0;
        bus.shamt  = 5'd3;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            cycle();
            n++;
        end
        chk("hold valid", 32'(bus.out_valid), 32'h1);
        hold = bus.dataout;
        chk("hold first", hold, 32'h0001_2345);
        repeat (3) begin
            cycle();
            chk("hold stable", bus.dataout, hold);
            chk("hold in_ready", 32'(bus.in_ready), 32'h0);
        end
        bus.out_ready = 1'b1;
        cycle();
        chk("after hs in_ready", 32'(bus.in_ready), 32'h1);
        chk("after hs valid", 32'(bus.out_valid), 32'h0);
        cycle();
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 40) begin
            cycle();
            n++;
        end
        chk("second latency", 32'(n), 32'd2);
        chk("second data", bus.dataout, 32'h0000_0780);
        cycle();
    endtask

    task automatic reset_test();
        bus.op        = 2'b00;
        bus.datain    = 32'hDEAD_BEEF;
        bus.shamt     = 5'd24;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        cycle();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst dataout", bus.dataout, 32'h0);
        chk("rst busy", 32'(bus.busy), 32'h0);
        cycle();
        cycle();
        #2;
        rst_n = 1'b1;
        cycle();
        chk("post rst in_ready", 32'(bus.in_ready), 32'h1);
        repeat (6) cycle();
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 2'b00;
        bus.datain    = '0;
        bus.shamt     = '0;
        bus.out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        compare();
        #2;
        rst_n = 1'b1;
        cycle();
        chk("first in_ready", 32'(bus.in_ready), 32'h1);

        run(2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 5, "sll31");
        run(2'b11, 32'h8000_0000, 5'd4, 32'hF800_0000, 2, "sra4");
        run(2'b01, 32'h8000_0000, 5'd4, 32'h0800_0000, 2, "srl4");
        run(2'b01, 32'h8000_0000, 5'd8, 32'h0080_0000, 3, "srl8");
        run(2'b00, 32'hA5A5_A5A5, 5'd0, 32'hA5A5_A5A5, ZLAT, "zero");
        run(2'b10, 32'h0000_0001, 5'd4, 32'h0000_0010, 2, "rsvd");
        run(2'b11, 32'h8000_0000, 5'd17, 32'hFFFF_C000, 4, "sra17");
        hold_test();
        reset_test();

        for (int i = 0; i < 3000; i++) begin
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.op        = 2'($urandom);
            bus.datain    = $urandom;
            bus.shamt     = 5'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (8) cycle();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
